// File: rtl/uart_map_pkg.sv
// Register map of the UART as seen from the transmit feeder, plus status-word field helpers.
package uart_map_pkg;

    localparam int UART_AW = 6;
    localparam int UART_DW = 32;

    localparam logic [UART_AW-1:0] UART_STATUS_ADDR = 6'h00;
    localparam logic [UART_AW-1:0] UART_RXBUF_BASE  = 6'h10;
    localparam logic [UART_AW-1:0] UART_TXBUF_BASE  = 6'h20;

    // Status word layout: tx_ptr [3:0], tx_head [7:4], rx_ptr [11:8].
    localparam int PTR_W       = 4;
    localparam int TX_PTR_LSB  = 0;
    localparam int TX_HEAD_LSB = 4;
    localparam int RX_PTR_LSB  = 8;
    localparam int RING_DEPTH  = 16;

    typedef struct packed {
        logic [2:0]       state;
        logic [PTR_W-1:0] tx_ptr;
        logic [PTR_W-1:0] tx_head;
    } feeder_dbg_t;

    // One slot is always left free so head == ptr can only mean empty.
    function automatic logic ring_full(input logic [PTR_W-1:0] ptr,
                                       input logic [PTR_W-1:0] head);
        logic [PTR_W-1:0] ptr_nx;
        ptr_nx = ptr + 4'd1;
        return ptr_nx == head;
    endfunction

    function automatic logic [UART_AW-1:0] tx_word_addr(input logic [UART_AW-1:0] base,
                                                        input logic [PTR_W-1:0]   ptr);
        return base | {2'b00, ptr[3:2], 2'b00};
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Upstream byte stream plus the UART register port driven by the feeder.
interface uart_tx_feeder_if;
    import uart_map_pkg::*;

    // in_data is transferred on a rising edge where in_valid and in_ready are
    // both high; in_valid/in_data are ignored whenever in_ready is low.
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic [UART_AW-1:0] uart_addr;
    logic [UART_DW-1:0] uart_rdata;
    logic [UART_DW-1:0] uart_wdata;
    logic               uart_we;

    modport master (
        output in_valid, in_data, uart_rdata,
        input  in_ready, uart_addr, uart_wdata, uart_we
    );

    modport slave (
        input  in_valid, in_data, uart_rdata,
        output in_ready, uart_addr, uart_wdata, uart_we
    );

endinterface

// File: rtl/uart_tx_feeder_byte_lane_merge.sv
// Replaces one byte lane of a 32-bit word; lane 0 is bits 7:0.
module byte_lane_merge (
    input  logic [31:0] word_in,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  lane,
    output logic [31:0] word_out
);

    always_comb begin
        word_out = word_in;
        word_out[{lane, 3'b000} +: 8] = byte_in;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Moves upstream bytes into the UART send ring by read-modify-write of the buffer
// word, then publishes each byte by advancing the UART tx pointer.
module uart_tx_feeder #(
    parameter logic [5:0] STATUS_ADDR = uart_map_pkg::UART_STATUS_ADDR,
    parameter logic [5:0] TXBUF_BASE  = uart_map_pkg::UART_TXBUF_BASE
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_tx_feeder_if.slave           bus,
    output logic                      busy,
    output uart_map_pkg::feeder_dbg_t dbg
);
    import uart_map_pkg::*;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_POLL    = 3'd1,
        S_READ    = 3'd2,
        S_WRITE   = 3'd3,
        S_ADVANCE = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [7:0]         byte_q;
    logic [PTR_W-1:0]   tx_ptr, tx_head;
    logic [UART_DW-1:0] word_q;
    logic [UART_DW-1:0] merged_word;
    logic [PTR_W-1:0]   st_ptr, st_head, ptr_nx;

    assign st_ptr  = bus.uart_rdata[TX_PTR_LSB  +: PTR_W];
    assign st_head = bus.uart_rdata[TX_HEAD_LSB +: PTR_W];
    assign ptr_nx  = tx_ptr + 4'd1;

    byte_lane_merge u_merge (
        .word_in  (word_q),
        .byte_in  (byte_q),
        .lane     (tx_ptr[1:0]),
        .word_out (merged_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            byte_q  <= '0;
            tx_ptr  <= '0;
            tx_head <= '0;
            word_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (bus.in_valid) byte_q <= bus.in_data;
                S_POLL: begin
                    tx_ptr  <= st_ptr;
                    tx_head <= st_head;
                end
                S_READ: word_q <= bus.uart_rdata;
                default: ;
            endcase
        end
    end

    // A stale tx_head only under-reports free space, so polling is race-safe.
    always_comb begin
        state_nx       = state;
        bus.uart_addr  = STATUS_ADDR;
        bus.uart_wdata = '0;
        bus.uart_we    = 1'b0;
        case (state)
            S_IDLE: if (bus.in_valid && bus.in_ready) state_nx = S_POLL;
            S_POLL: if (!ring_full(st_ptr, st_head)) state_nx = S_READ;
            S_READ: begin
                bus.uart_addr = tx_word_addr(TXBUF_BASE, tx_ptr);
                state_nx      = S_WRITE;
            end
            S_WRITE: begin
                bus.uart_addr  = tx_word_addr(TXBUF_BASE, tx_ptr);
                bus.uart_we    = 1'b1;
                bus.uart_wdata = merged_word;
                state_nx       = S_ADVANCE;
            end
            S_ADVANCE: begin
                bus.uart_we    = 1'b1;
                bus.uart_wdata = {28'b0, ptr_nx};
                state_nx       = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.in_ready = (state == S_IDLE) && !rst;
    assign busy         = (state != S_IDLE);
    assign dbg          = {state, tx_ptr, tx_head};

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: UART register model, vector table, stall/reset/stream sequences.
module tb_uart_tx_feeder;
    import uart_map_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_feeder_if bus ();
    logic        busy;
    feeder_dbg_t dbg;

    uart_tx_feeder #(.STATUS_ADDR(6'h00), .TXBUF_BASE(6'h20)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .dbg  (dbg)
    );

    // UART register model
    logic [3:0]  m_ptr = '0;
    logic [3:0]  m_head = '0;
    logic [31:0] m_words [4] = '{default: 32'h0};
    logic        m_overflow = 1'b0;
    int          drain_cnt = 0;
    logic        drain_en = 1'b0;
    logic        pre_go = 1'b0;
    logic [3:0]  pre_ptr = '0, pre_head = '0;
    logic [31:0] pre_word = '0;
    logic        pre_word_en = 1'b0;
    logic [7:0]  got_q [$];

    always_comb begin
        bus.uart_rdata = '0;
        if (bus.uart_addr == 6'h00)
            bus.uart_rdata = {20'h0, 4'hA, m_head, m_ptr};
        else if (bus.uart_addr[5:4] == 2'b10)
            bus.uart_rdata = m_words[bus.uart_addr[3:2]];
    end

    always @(posedge clk) begin
        if (pre_go) begin
            m_ptr      <= pre_ptr;
            m_head     <= pre_head;
            m_overflow <= 1'b0;
            if (pre_word_en) m_words[pre_ptr[3:2]] <= pre_word;
        end else begin
            if (bus.uart_we) begin
                if (bus.uart_addr == 6'h00) begin
                    m_ptr <= bus.uart_wdata[3:0];
                    if (bus.uart_wdata[3:0] == m_head) m_overflow <= 1'b1;
                end else if (bus.uart_addr[5:4] == 2'b10) begin
                    m_words[bus.uart_addr[3:2]] <= bus.uart_wdata;
                end
            end
            if (drain_en) begin
                if (drain_cnt == 19) begin
                    drain_cnt <= 0;
                    if (m_head != m_ptr) begin
                        got_q.push_back(m_words[m_head[3:2]][{m_head[1:0], 3'b000} +: 8]);
                        m_head <= m_head + 4'd1;
                    end
                end else begin
                    drain_cnt <= drain_cnt + 1;
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  ptr;
        logic [3:0]  head;
        logic [31:0] word;
        logic [7:0]  b;
        logic [5:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_adv;
    } vec_t;

    vec_t        vecs [6];
    logic [37:0] exp_wr_q [$];
    logic [7:0]  exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic preset(input logic [3:0] p, input logic [3:0] h,
                          input logic [31:0] w, input logic wen);
        pre_ptr = p; pre_head = h; pre_word = w; pre_word_en = wen; pre_go = 1'b1;
        @(negedge clk);
        pre_go = 1'b0;
    endtask

    // Returns at the negedge right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output logic ok);
        int cnt;
        cnt = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        ok = bus.in_ready;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    // Compares every UART write against the expected-write queue; noise on
    // in_valid/in_data while busy must not leak into the written byte.
    task automatic observe(input int ncyc, input string tag, output int ready_k);
        logic [37:0] e;
        ready_k = -1;
        for (int k = 0; k < ncyc; k++) begin
            if (dbg.state inside {3'd1, 3'd2, 3'd3}) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 8'($urandom_range(0, 255));
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.uart_we) begin
                if (exp_wr_q.size() == 0) begin
                    check($sformatf("%s_unexpected_write", tag), {26'h0, bus.uart_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_wr_q.pop_front();
                    check($sformatf("%s_waddr", tag), {26'h0, bus.uart_addr}, {26'h0, e[37:32]});
                    check($sformatf("%s_wdata", tag), bus.uart_wdata, e[31:0]);
                end
            end
            if (bus.in_ready && ready_k < 0) ready_k = k;
            @(negedge clk);
        end
        check($sformatf("%s_pending_writes", tag), exp_wr_q.size(), 0);
        exp_wr_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        int         rk;
        logic [7:0] stream [16];

        vecs[0] = '{4'd0,  4'd0, 32'h0000_0000, 8'h41, 6'h20, 32'h0000_0041, 32'h0000_0001};
        vecs[1] = '{4'd6,  4'd0, 32'hAABB_CCDD, 8'h5A, 6'h24, 32'hAA5A_CCDD, 32'h0000_0007};
        vecs[2] = '{4'd15, 4'd3, 32'h1122_3344, 8'h7E, 6'h2C, 32'h7E22_3344, 32'h0000_0000};
        vecs[3] = '{4'd1,  4'd1, 32'hDEAD_BEEF, 8'hC3, 6'h20, 32'hDEAD_C3EF, 32'h0000_0002};
        vecs[4] = '{4'd10, 4'd0, 32'hFFFF_FFFF, 8'h00, 6'h28, 32'hFF00_FFFF, 32'h0000_000B};
        vecs[5] = '{4'd13, 4'd2, 32'h0102_0304, 8'h99, 6'h2C, 32'h0102_9904, 32'h0000_000E};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_we", bus.uart_we, 0);
        check("rst_wdata", bus.uart_wdata, 0);
        check("rst_addr", bus.uart_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg.state, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            preset(vecs[i].ptr, vecs[i].head, vecs[i].word, 1'b1);
            exp_wr_q.push_back({vecs[i].exp_addr, vecs[i].exp_wdata});
            exp_wr_q.push_back({6'h00, vecs[i].exp_adv});
            send_byte(vecs[i].b, ok);
            if (ok) begin
                check($sformatf("v%0d_busy", i), busy, 1);
                observe(10, $sformatf("v%0d", i), rk);
                check($sformatf("v%0d_ready_latency", i), rk, 4);
            end
            exp_wr_q.delete();
        end

        // Full ring: ptr 4, head 5 holds the FSM in POLL until head moves.
        preset(4'd4, 4'd5, 32'h0000_0000, 1'b1);
        exp_wr_q.push_back({6'h24, 32'h0000_0033});
        exp_wr_q.push_back({6'h00, 32'h0000_0005});
        send_byte(8'h33, ok);
        bus.in_valid = 1'b0;
        if (ok) begin
            for (int k = 0; k < 8; k++) begin
                check("stall_we", bus.uart_we, 0);
                @(negedge clk);
            end
            check("stall_state", dbg.state, 3'd1);
            check("stall_addr", bus.uart_addr, 6'h00);
            preset(4'd4, 4'd6, 32'h0, 1'b0);
            observe(12, "stall", rk);
        end
        exp_wr_q.delete();

        // Reset landing in the WRITE cycle must suppress the ADVANCE write.
        preset(4'd2, 4'd0, 32'h0000_0000, 1'b1);
        send_byte(8'h55, ok);
        bus.in_valid = 1'b0;
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            check("rw_in_write_we", bus.uart_we, 1);
            rst = 1'b1;
            @(negedge clk);
            check("rw_rst_we", bus.uart_we, 0);
            check("rw_rst_busy", busy, 0);
            check("rw_rst_in_ready", bus.in_ready, 0);
            rst = 1'b0;
            @(negedge clk);
            check("rw_post_in_ready", bus.in_ready, 1);
            check("rw_post_busy", busy, 0);
            for (int k = 0; k < 5; k++) begin
                check("rw_no_advance_we", bus.uart_we, 0);
                @(negedge clk);
            end
            check("rw_ptr_unchanged", m_ptr, 4'd2);
        end

        // Streaming 16 bytes against a UART draining one byte per 20 cycles.
        for (int i = 0; i < 16; i++) stream[i] = 8'($urandom_range(0, 255));
        preset(4'd0, 4'd0, 32'h0, 1'b1);
        got_q.delete();
        drain_en = 1'b1;
        begin
            int sent;
            sent = 0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                if (sent < 16) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = stream[sent];
                    if (bus.in_ready) begin
                        exp_q.push_back(stream[sent]);
                        sent++;
                    end
                end else begin
                    bus.in_valid = 1'b0;
                end
                @(negedge clk);
                if (sent == 16 && got_q.size() == 16) break;
            end
        end
        bus.in_valid = 1'b0;
        drain_en = 1'b0;
        check("stream_count", got_q.size(), 16);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check("stream_missing_byte", 32'hFFFF_FFFF, {24'h0, e});
            end else begin
                check("stream_byte", {24'h0, got_q.pop_front()}, {24'h0, e});
            end
        end
        check("stream_extra_bytes", got_q.size(), 0);
        check("stream_no_overflow", m_overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter STATUS_ADDR, default 6'h00: UART status/pointer word address.
REQ-002 SHALL have parameter TXBUF_BASE, default 6'h20: base of the UART 4-word send buffer.
REQ-003 SHALL have port clk  input  1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1: upstream byte available.
REQ-006 SHALL have port in_data  input  8: upstream byte.
REQ-007 SHALL have port in_ready  output  1: byte accepted when in_valid and in_ready are both high on a rising edge.
REQ-008 SHALL have port uart_addr  output  6: UART register address.
REQ-009 SHALL have port uart_rdata  input  32: UART combinational read data for uart_addr.
REQ-010 SHALL have port uart_wdata  output  32: UART write data.
REQ-011 SHALL have port uart_we  output  1: UART write enable, sampled by the UART on the same edge.
REQ-012 SHALL have port busy  output  1: high whenever state is not IDLE.

Function
REQ-013 SHALL act as the sole writer of the UART register port, moving upstream bytes into the UART 16-byte send ring (4 words x 4 bytes; byte n sits in word n[3:2], lane n[1:0], lane 0 = bits 7:0).
REQ-014 SHALL interpret the status word as tx_ptr = bits 3:0, tx_head = bits 7:4, rx_ptr = bits 11:8 (ignored).
REQ-015 SHALL implement FSM IDLE -> POLL -> READ -> WRITE -> ADVANCE -> IDLE.
REQ-016 IDLE: in_ready = 1, uart_we = 0; on accept, latch in_data and go to POLL; otherwise stay.
REQ-017 POLL: uart_addr = STATUS_ADDR, latch tx_ptr and tx_head from uart_rdata; go to READ if not full, else stay in POLL and re-read every cycle.
REQ-018 Ring full SHALL be defined as (tx_ptr + 1) mod 16 == tx_head; empty (head == ptr) is never created by a write, so at most 15 bytes are pending.
REQ-019 READ: uart_addr = TXBUF_BASE | {tx_ptr[3:2], 2'b00}; latch uart_rdata as the current word.
REQ-020 WRITE: same address, uart_we = 1, uart_wdata = latched word with lane tx_ptr[1:0] replaced by the latched byte and other lanes unchanged.
REQ-021 ADVANCE: uart_addr = STATUS_ADDR, uart_we = 1, uart_wdata = {28'b0, (tx_ptr + 1) mod 16}; the pointer wraps from 15 to 0.
REQ-022 Latency: a byte accepted at edge N is written into the buffer at edge N+3 and published at edge N+4, with no full stall. in_ready returns high in the cycle after N+4, so peak throughput is 1 byte per 5 cycles.
REQ-023 uart_addr, uart_wdata, uart_we, in_ready and busy SHALL be decoded only from state and internal registers, with no combinational path from in_valid or in_data.
REQ-024 A tx_head advance by the UART during the sequence SHALL be tolerated: a stale head only under-reports free space.
REQ-025 In any non-IDLE state, in_ready = 0 and upstream in_valid/in_data changes SHALL be ignored.
REQ-026 Outside WRITE and ADVANCE, uart_we = 0 and uart_wdata = 0; in IDLE, uart_addr = STATUS_ADDR.

Reset
REQ-027 While rst is high at a rising edge: state <= IDLE, and latched byte, pointers and word <= 0.
REQ-028 During and directly after reset: in_ready = 0 while rst is high, then 1; uart_we = 0, uart_wdata = 0, uart_addr = STATUS_ADDR, busy = 0.
REQ-029 Reset mid-sequence SHALL abandon the byte. If reset hits before ADVANCE, the UART pointer is unchanged; a WRITE-only buffer modification is harmless because it is unpublished.

Structure
REQ-030 A shared package uart_map_pkg SHALL hold STATUS_ADDR, TXBUF_BASE, the RXBUF base 6'h10, the status field bit positions, and the 16-byte ring depth.
REQ-031 The FSM state enum SHALL be local to this module.
REQ-032 One sub-module, byte_lane_merge (32-bit word, 8-bit byte, 2-bit lane -> 32-bit word), is natural; the rest is flat.

Verification
REQ-033 Single byte: status 0x000, in_data 0x41 -> READ addr 0x20, WRITE addr 0x20 data 0x00000041, ADVANCE addr 0x00 data 0x00000001, in_ready high again 5 cycles after accept.
REQ-034 Lane merge: ptr = 6, word at 0x24 = 0xAABBCCDD, byte 0x5A -> WRITE addr 0x24 data 0xAA5ACCDD, ADVANCE data 0x7.
REQ-035 Wrap: ptr = 15, head = 3, byte 0x7E -> WRITE addr 0x2C lane 3, ADVANCE data 0x0.
REQ-036 Full stall: ptr = 4, head = 5 -> FSM stays in POLL with uart_we = 0. When the model moves head to 6, the sequence completes with ADVANCE data 0x5.
REQ-037 Reset in WRITE: assert rst in the WRITE cycle -> no ADVANCE write; next cycle uart_we = 0, busy = 0, in_ready = 1 once rst is low.
REQ-038 Back-to-back: in_valid held high with 16 bytes against a UART model draining every 20 cycles -> all bytes arrive in order, never more than 15 pending, none lost or duplicated.
